// File: rtl/sign_extend_pkg.sv
// ---------------------------------------------------------------------------
// sign_extend_pkg
// Shared MIPS datapath constants used by the immediate-extension unit.
//   IMM_W  : width of the raw instruction immediate (instr[15:0])
//   WORD_W : datapath word width
// ---------------------------------------------------------------------------
package sign_extend_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  // Bundle of every extended form, handy when a consumer wants them together.
  typedef struct packed {
    logic [WORD_W-1:0] sext;
    logic [WORD_W-1:0] zext;
    logic [WORD_W-1:0] upper;
    logic [WORD_W-1:0] br_off;
  } ext_words_t;

endpackage

// File: rtl/sign_extend_if.sv
// ---------------------------------------------------------------------------
// sign_extend_if
// Bus between instruction decode and the immediate-extension unit.
//   i_data / i_valid           : raw immediate and its qualifier (from decode)
//   o_data, o_zext, o_upper,
//   o_br_off, o_neg            : combinational extended forms
//   o_*_q, o_valid_q           : one-cycle registered copies
// Modports: master = decode/testbench side, slave = extension unit.
// ---------------------------------------------------------------------------
interface sign_extend_if
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
);

  logic [IN_W-1:0]  i_data;
  logic             i_valid;

  logic [OUT_W-1:0] o_data;
  logic [OUT_W-1:0] o_zext;
  logic [OUT_W-1:0] o_upper;
  logic [OUT_W-1:0] o_br_off;
  logic             o_neg;

  logic [OUT_W-1:0] o_data_q;
  logic [OUT_W-1:0] o_zext_q;
  logic [OUT_W-1:0] o_upper_q;
  logic [OUT_W-1:0] o_br_off_q;
  logic             o_valid_q;

  modport master (
    output i_data, i_valid,
    input  o_data, o_zext, o_upper, o_br_off, o_neg,
    input  o_data_q, o_zext_q, o_upper_q, o_br_off_q, o_valid_q
  );

  modport slave (
    input  i_data, i_valid,
    output o_data, o_zext, o_upper, o_br_off, o_neg,
    output o_data_q, o_zext_q, o_upper_q, o_br_off_q, o_valid_q
  );

endinterface

// File: rtl/sign_extend_ext_reg.sv
// ---------------------------------------------------------------------------
// ext_reg
// Valid-gated W-bit register with synchronous active-high reset.
//   i_clk : clock, rising edge
//   i_rst : synchronous reset, clears the register, beats i_en
//   i_en  : load enable; register holds when low
//   i_d   : data to load
//   o_q   : registered value
// ---------------------------------------------------------------------------
module ext_reg #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Reset wins over the enable so an item presented during reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sign_extend.sv
// ---------------------------------------------------------------------------
// sign_extend
// Immediate-extension unit between decode and the ALU operand mux. Widens the
// IN_W-bit immediate to OUT_W bits in every form the datapath uses, purely
// combinationally, and also offers a one-stage registered copy with a valid.
//   i_clk      : clock (registered stage only)
//   i_rst      : synchronous active-high reset (registered stage only)
//   bus.i_data : raw immediate, bus.i_valid qualifies it for the register
//   bus.o_data / o_zext / o_upper / o_br_off / o_neg : combinational forms
//   bus.o_*_q / o_valid_q                            : registered forms
// OUT_W must be at least 2*IN_W so the upper form fits.
// ---------------------------------------------------------------------------
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sign_extend_if.slave  bus
);

  logic [OUT_W-1:0] w_data;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_br_off;
  logic             w_neg;
  logic             r_valid_q;

  assign w_neg  = bus.i_data[IN_W-1];
  assign w_data = {{(OUT_W-IN_W){w_neg}}, bus.i_data};
  assign w_zext = {{(OUT_W-IN_W){1'b0}}, bus.i_data};

  // Shifting the zero-extended value keeps this legal even when OUT_W is
  // exactly 2*IN_W, where a zero-width pad replication would not be.
  assign w_upper = w_zext << IN_W;

  // Branch offset drops the two top bits of the sign-extended value; no
  // saturation, this is just the word-to-byte scaling.
  assign w_br_off = {w_data[OUT_W-3:0], 2'b00};

  assign bus.o_data   = w_data;
  assign bus.o_zext   = w_zext;
  assign bus.o_upper  = w_upper;
  assign bus.o_br_off = w_br_off;
  assign bus.o_neg    = w_neg;

  ext_reg #(.W(OUT_W)) u_reg_data (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (bus.i_valid),
    .i_d   (w_data),
    .o_q   (bus.o_data_q)
  );

  ext_reg #(.W(OUT_W)) u_reg_zext (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (bus.i_valid),
    .i_d   (w_zext),
    .o_q   (bus.o_zext_q)
  );

  ext_reg #(.W(OUT_W)) u_reg_upper (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (bus.i_valid),
    .i_d   (w_upper),
    .o_q   (bus.o_upper_q)
  );

  ext_reg #(.W(OUT_W)) u_reg_br_off (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (bus.i_valid),
    .i_d   (w_br_off),
    .o_q   (bus.o_br_off_q)
  );

  // The valid flag tracks i_valid every cycle rather than holding, so a
  // consumer sees exactly one pulse per captured item.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= bus.i_valid;
    end
  end

  assign bus.o_valid_q = r_valid_q;

endmodule

// File: tb/tb_sign_extend.sv
// ---------------------------------------------------------------------------
// tb_sign_extend
// Self-checking bench for sign_extend. Stimulus drives the bus on the falling
// edge and pushes the expected registered result for the following rising
// edge into a queue; a monitor pops one entry per rising edge and compares.
// Combinational outputs are checked right after each drive.
// ---------------------------------------------------------------------------
module tb_sign_extend;
  import sign_extend_pkg::*;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [31:0] z;
    logic [31:0] u;
    logic [31:0] b;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   started;
  exp_t expQ[$];
  exp_t held;

  sign_extend_if bus ();

  sign_extend dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: treat the immediate as a signed/unsigned number.
  function automatic logic [31:0] modelSext(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    return 32'(v);
  endfunction

  function automatic logic [31:0] modelZext(input logic [15:0] d);
    int unsigned v;
    v = int'(d);
    return 32'(v);
  endfunction

  function automatic logic [31:0] modelUpper(input logic [15:0] d);
    longint unsigned v;
    v = longint'(d) * 65536;
    return v[31:0];
  endfunction

  function automatic logic [31:0] modelBr(input logic [15:0] d);
    longint v;
    v = longint'($signed(d)) * 4;
    return v[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational forms, and record
  // what the registered stage must show after the next rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.i_valid = v;
    bus.i_data  = d;
    if (r) begin
      held.d = '0; held.z = '0; held.u = '0; held.b = '0;
    end else if (v) begin
      held.d = modelSext(d);
      held.z = modelZext(d);
      held.u = modelUpper(d);
      held.b = modelBr(d);
    end
    e   = held;
    e.v = v & ~r;
    expQ.push_back(e);
    started = 1'b1;
    #1;
    checkOutput("o_data",   bus.o_data,   modelSext(d));
    checkOutput("o_zext",   bus.o_zext,   modelZext(d));
    checkOutput("o_upper",  bus.o_upper,  modelUpper(d));
    checkOutput("o_br_off", bus.o_br_off, modelBr(d));
    checkOutput("o_neg",    32'(bus.o_neg), 32'(d >= 16'h8000));
  endtask

  // Monitor: one expected registered result per rising edge once started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_underflow got empty want entry");
        end else begin
          e = expQ.pop_front();
          checkOutput("o_valid_q",  32'(bus.o_valid_q), 32'(e.v));
          checkOutput("o_data_q",   bus.o_data_q,   e.d);
          checkOutput("o_zext_q",   bus.o_zext_q,   e.z);
          checkOutput("o_upper_q",  bus.o_upper_q,  e.u);
          checkOutput("o_br_off_q", bus.o_br_off_q, e.b);
        end
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    started     = 1'b0;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    held        = '{v: 1'b0, d: '0, z: '0, u: '0, b: '0};

    // Reset for two cycles, then directed vectors.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0004);
    applyStimulus(1'b0, 1'b0, 16'hABCD);
    applyStimulus(1'b0, 1'b1, 16'hF123);
    applyStimulus(1'b0, 1'b1, 16'h7321);
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 16'h8000);
    applyStimulus(1'b1, 1'b1, 16'hF123);
    applyStimulus(1'b0, 1'b1, 16'h7FFF);
    applyStimulus(1'b0, 1'b0, 16'h0001);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 16'($urandom));
    end

    @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d want 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_extend.md
# sign_extend

Immediate-extension unit for the MIPS datapath, placed between instruction decode and the ALU operand multiplexer. It widens the 16-bit instruction immediate to 32 bits and produces every extended form the datapath needs: sign-extended, zero-extended, LUI (upper) and branch offset. All forms are available combinationally. A one-stage registered copy with a valid flag also exists for pipelined use.

## Interface
Parameters:
- IN_W, default 16: immediate width.
- OUT_W, default 32: extended width. Must be greater than IN_W and at least 2*IN_W for the upper form.

Ports:
- i_clk, input, 1: clock, rising edge. Drives the registered stage only.
- i_rst, input, 1: reset. One clock; reset is synchronous and active-high.
- i_data, input, IN_W: raw immediate (instr[15:0]).
- i_valid, input, 1: qualifies i_data for the registered stage.
- o_data, output, OUT_W: sign-extended immediate, combinational.
- o_zext, output, OUT_W: zero-extended immediate, combinational.
- o_upper, output, OUT_W: {i_data, IN_W'b0} zero-padded to OUT_W, combinational.
- o_br_off, output, OUT_W: o_data shifted left 2, combinational.
- o_neg, output, 1: i_data[IN_W-1], combinational.
- o_data_q, output, OUT_W: registered o_data.
- o_zext_q, output, OUT_W: registered o_zext.
- o_upper_q, output, OUT_W: registered o_upper.
- o_br_off_q, output, OUT_W: registered o_br_off.
- o_valid_q, output, 1: registered i_valid.

## Operation
- o_data = {(OUT_W-IN_W){i_data[IN_W-1]}, i_data}.
- o_zext = {(OUT_W-IN_W){1'b0}, i_data}.
- o_upper = i_data placed in bits [2*IN_W-1:IN_W], with zeros in all other bits.
- o_br_off = {o_data[OUT_W-3:0], 2'b00}. The two MSBs of o_data are discarded. The result is not saturated.
- o_neg equals i_data MSB.
- Combinational outputs depend only on i_data. They must be valid with i_clk and i_rst undriven.
- Registered stage:
  - When i_valid=1 at a rising edge, all *_q outputs load the current combinational values.
  - When i_valid=0, the data *_q outputs hold their previous values.
  - o_valid_q follows i_valid every cycle.
- No arithmetic beyond replication and shift. No overflow conditions exist.

## Timing
- Combinational path: zero latency, i_data to o_data/o_zext/o_upper/o_br_off/o_neg.
- Registered path: latency of one cycle.
- Reset: while i_rst=1 at a rising edge, all *_q outputs and o_valid_q become 0. Reset overrides i_valid.
- Reset has no effect on the combinational outputs.
- Reset mid-stream: the item presented in the reset cycle is dropped. The next i_valid after reset deasserts is captured normally.
- Back-to-back i_valid: one capture per cycle, no bubbles required.

## Structure
- The shared MIPS package holds the localparams IMM_W=16 and WORD_W=32. The top level binds the parameters to these values.
- One natural sub-module, `ext_reg`: the valid-gated OUT_W register with synchronous reset. It is instantiated four times for the data outputs. o_valid_q is a plain flop.
- All extension logic is continuous assignments in the top module.

## Test plan
- i_data=16'hF123 -> after settle, o_data=32'hFFFF_F123, o_zext=32'h0000_F123, o_neg=1.
- i_data=16'h7321 -> o_data=32'h0000_7321, o_upper=32'h7321_0000, o_neg=0.
- i_data=16'hFFFF -> o_br_off=32'hFFFF_FFFC. i_data=16'h8000 -> o_data=32'hFFFF_8000, o_br_off=32'hFFFE_0000.
- Registered stage: i_rst=1 for 2 cycles -> all *_q=0. Then i_valid=1, i_data=16'h0004 -> next cycle o_data_q=32'h0000_0004, o_br_off_q=32'h0000_0010, o_valid_q=1.
- Hold: i_valid=0, i_data changed to 16'hABCD -> *_q unchanged, o_valid_q=0.
- Reset priority: i_rst=1 together with i_valid=1 and i_data=16'hF123 -> *_q=0 and o_valid_q=0 after the edge.
